// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the LEGv8 encoder/decoder path.
//   instr_op_t    - the eleven-instruction subset, as carried on in_op
//   enc_state_t   - instr_encoder FSM states
//   OPC_* / COND_* - fixed opcode and condition fields
//   *_LSB         - bit positions of the variable instruction fields
//   fits_unsigned / fits_signed - immediate range helpers
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADDI = 4'd0,
        OP_ADDS = 4'd1,
        OP_B    = 4'd2,
        OP_BLT  = 4'd3,
        OP_CBZ  = 4'd4,
        OP_LDUR = 4'd5,
        OP_LSL  = 4'd6,
        OP_LSR  = 4'd7,
        OP_MUL  = 4'd8,
        OP_STUR = 4'd9,
        OP_SUBS = 4'd10
    } instr_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } enc_state_t;

    // Opcode fields
    localparam logic [9:0]  OPC_ADDI  = 10'b1001000100;
    localparam logic [10:0] OPC_ADDS  = 11'b10101011000;
    localparam logic [10:0] OPC_SUBS  = 11'b11101011000;
    localparam logic [10:0] OPC_MUL   = 11'b10011011000;
    localparam logic [10:0] OPC_LSL   = 11'b11010011011;
    localparam logic [10:0] OPC_LSR   = 11'b11010011010;
    localparam logic [10:0] OPC_LDUR  = 11'b11111000010;
    localparam logic [10:0] OPC_STUR  = 11'b11111000000;
    localparam logic [5:0]  OPC_B     = 6'b000101;
    localparam logic [7:0]  OPC_BLT   = 8'b01010100;
    localparam logic [7:0]  OPC_CBZ   = 8'b10110100;
    localparam logic [4:0]  COND_LT   = 5'b01011;
    // MUL reuses the shamt slot as the fixed Ra=XZR field
    localparam logic [5:0]  SHAMT_MUL = 6'b011111;

    // Field positions (LSB of each field)
    localparam int RD_LSB    = 0;
    localparam int RN_LSB    = 5;
    localparam int IMM19_LSB = 5;
    localparam int SHAMT_LSB = 10;
    localparam int IMM12_LSB = 10;
    localparam int DADDR_LSB = 12;
    localparam int RM_LSB    = 16;
    localparam int OP11_LSB  = 21;
    localparam int OP10_LSB  = 22;
    localparam int OP8_LSB   = 24;
    localparam int OP6_LSB   = 26;

    // True when imm, read unsigned, is below 2**bits.
    function automatic logic fits_unsigned(input logic [25:0] imm, input int unsigned bits);
        return ((imm >> bits) == 26'd0);
    endfunction

    // True when imm, read as two's complement, fits a signed field of 'bits' bits:
    // everything from bit (bits-1) upward must be a copy of the sign.
    function automatic logic fits_signed(input logic [25:0] imm, input int unsigned bits);
        logic [25:0] hi;
        hi = 26'($signed(imm) >>> (bits - 32'd1));
        return (hi == 26'd0) || (hi == {26{1'b1}});
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: instruction-field stream plus instruction-memory write port.
//   in_valid/in_ready      - stream handshake
//   in_op/in_rd/in_rn/in_rm/in_imm - decoded instruction fields
//   wr_en/wr_addr/wr_data  - instruction-memory write strobe, word address, word
// master = field producer / memory side, slave = encoder.
interface instr_encoder_if #(parameter int ADDR_W = 6);

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rn;
    logic [4:0]        in_rm;
    logic [25:0]       in_imm;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output in_valid, in_op, in_rd, in_rn, in_rm, in_imm,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rn, in_rm, in_imm,
        output in_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/instr_pack.sv
// instr_pack: purely combinational LEGv8 field packer.
//   op, rd, rn, rm, imm - decoded fields (op may hold illegal codes > 10)
//   word                - 32-bit machine word (0 on error)
//   range_err           - illegal op or immediate out of range for op
// Usable stand-alone as a reference encoder.
module instr_pack
    import cpu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [25:0] imm,
    output logic [31:0] word,
    output logic        range_err
);

    // Pack fields by op and flag illegal ops / out-of-range immediates
    always_comb begin
        word      = 32'h0000_0000;
        range_err = 1'b0;
        case (op)
            OP_ADDI: begin
                word[OP10_LSB +: 10]  = OPC_ADDI;
                word[IMM12_LSB +: 12] = imm[11:0];
                word[RN_LSB +: 5]     = rn;
                word[RD_LSB +: 5]     = rd;
                range_err             = !fits_unsigned(imm, 32'd12);
            end
            OP_ADDS, OP_SUBS, OP_MUL: begin
                if (op == OP_ADDS) begin
                    word[OP11_LSB +: 11] = OPC_ADDS;
                end else if (op == OP_SUBS) begin
                    word[OP11_LSB +: 11] = OPC_SUBS;
                end else begin
                    word[OP11_LSB +: 11]  = OPC_MUL;
                    word[SHAMT_LSB +: 6]  = SHAMT_MUL;
                end
                word[RM_LSB +: 5] = rm;
                word[RN_LSB +: 5] = rn;
                word[RD_LSB +: 5] = rd;
            end
            OP_LSL, OP_LSR: begin
                // Rm field is forced to zero; shift amount comes from imm
                if (op == OP_LSL) begin
                    word[OP11_LSB +: 11] = OPC_LSL;
                end else begin
                    word[OP11_LSB +: 11] = OPC_LSR;
                end
                word[SHAMT_LSB +: 6] = imm[5:0];
                word[RN_LSB +: 5]    = rn;
                word[RD_LSB +: 5]    = rd;
                range_err            = !fits_unsigned(imm, 32'd6);
            end
            OP_LDUR, OP_STUR: begin
                if (op == OP_LDUR) begin
                    word[OP11_LSB +: 11] = OPC_LDUR;
                end else begin
                    word[OP11_LSB +: 11] = OPC_STUR;
                end
                word[DADDR_LSB +: 9] = imm[8:0];
                word[RN_LSB +: 5]    = rn;
                word[RD_LSB +: 5]    = rd;
                range_err            = !fits_signed(imm, 32'd9);
            end
            OP_B: begin
                word[OP6_LSB +: 6] = OPC_B;
                word[25:0]         = imm;
            end
            OP_BLT: begin
                word[OP8_LSB +: 8]    = OPC_BLT;
                word[IMM19_LSB +: 19] = imm[18:0];
                word[RD_LSB +: 5]     = COND_LT;
                range_err             = !fits_signed(imm, 32'd19);
            end
            OP_CBZ: begin
                word[OP8_LSB +: 8]    = OPC_CBZ;
                word[IMM19_LSB +: 19] = imm[18:0];
                word[RD_LSB +: 5]     = rd;
                range_err             = !fits_signed(imm, 32'd19);
            end
            default: begin
                word      = 32'h0000_0000;
                range_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts instruction fields on a valid/ready stream, encodes them
// and writes the words sequentially into instruction memory.
//   clk, reset_n    - clock, asynchronous active-low reset
//   start/base_addr - begin (or restart) a program at base_addr
//   finish          - end the current program
//   bus             - field stream in, memory write port out (slave modport)
//   err             - one-cycle pulse for an illegal op / immediate
//   busy            - program in progress (LOAD or FULL)
//   count           - words written since the last start
module instr_encoder
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    instr_encoder_if.slave    bus,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    enc_state_t        state_r;
    enc_state_t        state_s;
    logic [ADDR_W-1:0] next_addr_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [31:0]       wr_data_r;
    logic              wr_en_r;
    logic              err_r;
    logic [ADDR_W:0]   count_r;

    logic              in_ready_s;
    logic              accept_s;
    logic              good_s;
    logic              last_s;
    logic [31:0]       word_s;
    logic              range_err_s;

    instr_pack u_pack (
        .op        (bus.in_op),
        .rd        (bus.in_rd),
        .rn        (bus.in_rn),
        .rm        (bus.in_rm),
        .imm       (bus.in_imm),
        .word      (word_s),
        .range_err (range_err_s)
    );

    // start/finish close the input for the cycle so control always wins over data
    assign in_ready_s = (state_r == ST_LOAD) && !finish && !start;
    assign accept_s   = bus.in_valid && in_ready_s;
    assign good_s     = accept_s && !range_err_s;
    // The word being accepted goes to the top address: no further room
    assign last_s     = &next_addr_r;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; start has priority over finish
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (start) begin
                    state_s = ST_LOAD;
                end else if (finish) begin
                    state_s = ST_IDLE;
                end else if (good_s && last_s) begin
                    state_s = ST_FULL;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_FULL: begin
                if (start) begin
                    state_s = ST_LOAD;
                end else if (finish) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FULL;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Write strobe, error pulse and encoded-word register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_r   <= 1'b0;
            err_r     <= 1'b0;
            wr_data_r <= 32'h0000_0000;
        end else begin
            wr_en_r <= good_s;
            err_r   <= accept_s && range_err_s;
            if (good_s) begin
                wr_data_r <= word_s;
            end
        end
    end

    // Address pointer, presented write address and word count.
    // wr_addr_r shows the address of the write in flight; next_addr_r is where
    // the following accept will land and saturates at the top address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            next_addr_r <= {ADDR_W{1'b0}};
            wr_addr_r   <= {ADDR_W{1'b0}};
            count_r     <= {(ADDR_W+1){1'b0}};
        end else if (start) begin
            next_addr_r <= base_addr;
            wr_addr_r   <= base_addr;
            count_r     <= {(ADDR_W+1){1'b0}};
        end else if (good_s) begin
            wr_addr_r <= next_addr_r;
            count_r   <= count_r + CNT_ONE;
            if (!last_s) begin
                next_addr_r <= next_addr_r + ADDR_ONE;
            end
        end
    end

    assign bus.in_ready = in_ready_s;
    assign bus.wr_en    = wr_en_r;
    assign bus.wr_addr  = wr_addr_r;
    assign bus.wr_data  = wr_data_r;
    assign err          = err_r;
    assign busy         = (state_r != ST_IDLE);
    assign count        = count_r;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table-driven bench for instr_encoder (ADDR_W=6) plus a
// small ADDR_W=2 instance for the FULL boundary.
module tb_instr_encoder;

    logic clk = 1'b0;
    logic reset_n;
    logic start6, finish6, start2, finish2;
    logic [5:0] base6;
    logic [1:0] base2;
    logic err6, busy6, err2, busy2;
    logic [6:0] count6;
    logic [2:0] count2;

    int errors = 0;
    int checks = 0;

    instr_encoder_if #(.ADDR_W(6)) if6 ();
    instr_encoder_if #(.ADDR_W(2)) if2 ();

    instr_encoder #(.ADDR_W(6)) dut6 (
        .clk(clk), .reset_n(reset_n), .start(start6), .base_addr(base6),
        .finish(finish6), .bus(if6), .err(err6), .busy(busy6), .count(count6)
    );

    instr_encoder #(.ADDR_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .base_addr(base2),
        .finish(finish2), .bus(if2), .err(err2), .busy(busy2), .count(count2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [25:0] imm;
        logic [31:0] word;
        logic        err;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive6(input vec_t v, input logic valid);
        if6.in_valid = valid;
        if6.in_op    = v.op;
        if6.in_rd    = v.rd;
        if6.in_rn    = v.rn;
        if6.in_rm    = v.rm;
        if6.in_imm   = v.imm;
    endtask

    task automatic drive2(input vec_t v, input logic valid);
        if2.in_valid = valid;
        if2.in_op    = v.op;
        if2.in_rd    = v.rd;
        if2.in_rn    = v.rn;
        if2.in_rm    = v.rm;
        if2.in_imm   = v.imm;
    endtask

    initial begin
        int exp_addr;
        int last_addr;
        int exp_cnt;

        // op, rd, rn, rm, imm, expected word, expected err
        vecs[0]  = '{4'd0,  5'd1, 5'd31, 5'd0,  26'd5,        32'h910017E1, 1'b0}; // ADDI
        vecs[1]  = '{4'd2,  5'd0, 5'd0,  5'd0,  26'h3FFFFFF,  32'h17FFFFFF, 1'b0}; // B
        vecs[2]  = '{4'd5,  5'd2, 5'd3,  5'd0,  26'h3FFFFF8,  32'hF85F8062, 1'b0}; // LDUR -8
        vecs[3]  = '{4'd3,  5'd0, 5'd0,  5'd0,  26'd2,        32'h5400004B, 1'b0}; // BLT 2
        vecs[4]  = '{4'd0,  5'd1, 5'd2,  5'd0,  26'd4096,     32'h00000000, 1'b1}; // ADDI too big
        vecs[5]  = '{4'd12, 5'd1, 5'd2,  5'd3,  26'd0,        32'h00000000, 1'b1}; // illegal op
        vecs[6]  = '{4'd1,  5'd1, 5'd2,  5'd3,  26'd0,        32'hAB030041, 1'b0}; // ADDS
        vecs[7]  = '{4'd10, 5'd4, 5'd5,  5'd6,  26'd0,        32'hEB0600A4, 1'b0}; // SUBS
        vecs[8]  = '{4'd8,  5'd7, 5'd8,  5'd9,  26'd0,        32'h9B097D07, 1'b0}; // MUL
        vecs[9]  = '{4'd6,  5'd1, 5'd2,  5'd31, 26'd4,        32'hD3601041, 1'b0}; // LSL 4, Rm forced 0
        vecs[10] = '{4'd7,  5'd3, 5'd4,  5'd0,  26'd63,       32'hD340FC83, 1'b0}; // LSR 63
        vecs[11] = '{4'd6,  5'd1, 5'd2,  5'd0,  26'd64,       32'h00000000, 1'b1}; // LSL 64
        vecs[12] = '{4'd9,  5'd5, 5'd6,  5'd0,  26'd255,      32'hF80FF0C5, 1'b0}; // STUR 255
        vecs[13] = '{4'd5,  5'd0, 5'd1,  5'd0,  26'h3FFFF00,  32'hF8500020, 1'b0}; // LDUR -256
        vecs[14] = '{4'd5,  5'd0, 5'd1,  5'd0,  26'h3FFFEFF,  32'h00000000, 1'b1}; // LDUR -257
        vecs[15] = '{4'd4,  5'd9, 5'd0,  5'd0,  26'h3FC0000,  32'hB4800009, 1'b0}; // CBZ -2^18
        vecs[16] = '{4'd3,  5'd0, 5'd0,  5'd0,  26'h0040000,  32'h00000000, 1'b1}; // BLT 2^18
        vecs[17] = '{4'd4,  5'd0, 5'd0,  5'd0,  26'h003FFFF,  32'hB47FFFE0, 1'b0}; // CBZ 2^18-1
        vecs[18] = '{4'd0,  5'd2, 5'd3,  5'd0,  26'd4095,     32'h913FFC62, 1'b0}; // ADDI 4095
        vecs[19] = '{4'd1,  5'd0, 5'd0,  5'd0,  26'h3FFFFFF,  32'hAB000000, 1'b0}; // ADDS imm ignored

        reset_n = 1'b0;
        start6 = 1'b0; finish6 = 1'b0; base6 = 6'd0;
        start2 = 1'b0; finish2 = 1'b0; base2 = 2'd0;
        drive6(vecs[0], 1'b0);
        drive2(vecs[0], 1'b0);

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_wr_en",    if6.wr_en,    32'd0);
        chk("rst_wr_addr",  if6.wr_addr,  32'd0);
        chk("rst_wr_data",  if6.wr_data,  32'd0);
        chk("rst_err",      err6,         32'd0);
        chk("rst_busy",     busy6,        32'd0);
        chk("rst_count",    count6,       32'd0);
        chk("rst_in_ready", if6.in_ready, 32'd0);
        chk("rst_busy2",    busy2,        32'd0);
        reset_n = 1'b1;

        // IDLE ignores valid data
        @(negedge clk);
        drive6(vecs[0], 1'b1);
        #1 chk("idle_in_ready", if6.in_ready, 32'd0);
        @(negedge clk);
        chk("idle_no_wr_en", if6.wr_en, 32'd0);
        chk("idle_count",    count6,    32'd0);
        drive6(vecs[0], 1'b0);

        // Start a program at address 0
        start6 = 1'b1; base6 = 6'd0;
        @(negedge clk);
        start6 = 1'b0;
        chk("start_busy", busy6, 32'd1);

        // Back-to-back vector table: check the result of vector i-1 while driving i
        exp_addr = 0; last_addr = 0; exp_cnt = 0;
        for (int i = 0; i <= NV; i++) begin
            if (i > 0) begin
                @(negedge clk);
                if (vecs[i-1].err) begin
                    chk($sformatf("v%0d_err", i-1),     err6,        32'd1);
                    chk($sformatf("v%0d_no_wr", i-1),   if6.wr_en,   32'd0);
                    chk($sformatf("v%0d_addr", i-1),    if6.wr_addr, 32'(last_addr));
                    chk($sformatf("v%0d_count", i-1),   count6,      32'(exp_cnt));
                end else begin
                    chk($sformatf("v%0d_wr_en", i-1),   if6.wr_en,   32'd1);
                    chk($sformatf("v%0d_no_err", i-1),  err6,        32'd0);
                    chk($sformatf("v%0d_data", i-1),    if6.wr_data, vecs[i-1].word);
                    chk($sformatf("v%0d_addr", i-1),    if6.wr_addr, 32'(exp_addr));
                    chk($sformatf("v%0d_count", i-1),   count6,      32'(exp_cnt + 1));
                    last_addr = exp_addr;
                    exp_addr++;
                    exp_cnt++;
                end
            end
            if (i < NV) begin
                drive6(vecs[i], 1'b1);
                #1 chk($sformatf("v%0d_ready", i), if6.in_ready, 32'd1);
            end else begin
                drive6(vecs[0], 1'b0);
            end
        end
        @(negedge clk);
        chk("idle_after_table_wr_en", if6.wr_en, 32'd0);

        // Restart at base 10, then finish in the same cycle as new valid data
        start6 = 1'b1; base6 = 6'd10;
        @(negedge clk);
        start6 = 1'b0;
        chk("restart_count", count6,      32'd0);
        chk("restart_addr",  if6.wr_addr, 32'd10);
        drive6(vecs[0], 1'b1);
        @(negedge clk);
        finish6 = 1'b1;
        drive6(vecs[1], 1'b1);
        #1;
        chk("fin_in_ready",     if6.in_ready, 32'd0);
        chk("fin_pending_wr",   if6.wr_en,    32'd1);
        chk("fin_pending_addr", if6.wr_addr,  32'd10);
        chk("fin_pending_data", if6.wr_data,  32'h910017E1);
        @(negedge clk);
        finish6 = 1'b0;
        drive6(vecs[0], 1'b0);
        chk("fin_idle_busy", busy6,     32'd0);
        chk("fin_no_accept", if6.wr_en, 32'd0);
        chk("fin_count",     count6,    32'd1);

        // ADDR_W=2: four writes fill memory, the fifth is held off
        start2 = 1'b1; base2 = 2'd0;
        @(negedge clk);
        start2 = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) begin
                @(negedge clk);
                chk($sformatf("full_w%0d_wr_en", k-1), if2.wr_en,   32'd1);
                chk($sformatf("full_w%0d_addr", k-1),  if2.wr_addr, 32'(k-1));
                chk($sformatf("full_w%0d_count", k-1), count2,      32'(k));
            end
            drive2(vecs[k == 4 ? 18 : k], 1'b1);
            #1 chk($sformatf("full_ready%0d", k), if2.in_ready, (k < 4) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        chk("full_fifth_no_wr", if2.wr_en,   32'd0);
        chk("full_count",       count2,      32'd4);
        chk("full_busy",        busy2,       32'd1);
        chk("full_addr_hold",   if2.wr_addr, 32'd3);
        chk("full_ready_low",   if2.in_ready, 32'd0);
        drive2(vecs[0], 1'b0);
        finish2 = 1'b1;
        @(negedge clk);
        finish2 = 1'b0;
        chk("full_finish_idle", busy2, 32'd0);

        // Asynchronous reset right after a handshake
        start6 = 1'b1; base6 = 6'd5;
        @(negedge clk);
        start6 = 1'b0;
        drive6(vecs[6], 1'b1);
        @(posedge clk);
        #1;
        drive6(vecs[0], 1'b0);
        reset_n = 1'b0;
        #1;
        chk("arst_wr_en",    if6.wr_en,    32'd0);
        chk("arst_wr_addr",  if6.wr_addr,  32'd0);
        chk("arst_wr_data",  if6.wr_data,  32'd0);
        chk("arst_busy",     busy6,        32'd0);
        chk("arst_count",    count6,       32'd0);
        chk("arst_in_ready", if6.in_ready, 32'd0);
        chk("arst_err",      err6,         32'd0);
        @(negedge clk);
        chk("arst_wr_en_hold", if6.wr_en, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
